// File: rtl/mul_pkg.sv
// Shared definitions for the Wallace-multiplier arbiter slice.
// Contents:
//   state_t             arbiter FSM states (IDLE, SETTLE, RESP)
//   MUL_WIDTH           default operand width
//   MUL_SETTLE_DEFAULT  default number of settle clocks for the tree
//   req_id_t            requester id (two requesters -> one bit)
package mul_pkg;

    localparam int MUL_WIDTH          = 32;
    localparam int MUL_SETTLE_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant.
// Ports:
//   valid0, valid1  in   requester valids
//   last_grant      in   requester granted most recently
//   grant           out  requester that wins this cycle
// With no valid at all the grant is 0; callers qualify it with the valids.
module rr_arb2
    import mul_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    output req_id_t grant
);

    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            // Tie: the requester that was not served last goes first.
            grant = ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/wallace_mul_arbiter.sv
// Shares one external combinational Wallace-tree multiplier between two
// requesters. A round-robin winner's operands are registered onto the tree
// inputs, held for SETTLE_CYCLES clocks while the adder tree ripples, then
// the product is captured and returned tagged with the requester id.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/_a/_b/_ready   requester N operand channel (N = 0, 1)
//   mul_a, mul_b              registered operands driving the tree
//   mul_p                     tree product (combinational, external)
//   rsp_valid/_id/_p/_ready   result channel
//   busy                      high whenever the FSM is not IDLE
// Handshake: a transfer happens at a rising edge where valid and ready are
// both high; a source holds valid and its payload stable until that edge,
// and ready here never depends on anything but state, grant, valid and rst.
// SETTLE_CYCLES must lie in 1..15 (the counter is 4 bits).
module wallace_mul_arbiter
    import mul_pkg::*;
#(
    parameter int WIDTH         = MUL_WIDTH,
    parameter int SETTLE_CYCLES = MUL_SETTLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_p,
    input  logic                 rsp_ready,
    output logic                 busy
);

    state_t    state;
    state_t    state_nxt;
    req_id_t   last_grant;
    req_id_t   grant;
    logic [3:0] cnt;
    logic       accept;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                 state_nxt = SETTLE;
            SETTLE:  if (cnt == 4'd0)            state_nxt = RESP;
            RESP:    if (rsp_ready)              state_nxt = IDLE;
            default:                             state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state. rsp_valid is exactly "in RESP", so it is
    // cleared by reset and by the response handshake with the state itself.
    always_comb begin
        req0_ready = (state == IDLE) && (grant == 1'b0) && req0_valid && !rst;
        req1_ready = (state == IDLE) && (grant == 1'b1) && req1_valid && !rst;
        accept     = req0_ready || req1_ready;
        rsp_valid  = (state == RESP);
        busy       = (state != IDLE);
    end

    // Datapath: operand registers, settle counter and result capture.
    // Operands are only rewritten on an accept, so they stay frozen through
    // SETTLE and keep their last value afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_id     <= 1'b0;
            rsp_p      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a      <= grant ? req1_a : req0_a;
                        mul_b      <= grant ? req1_b : req0_b;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        // Loading N-1 makes the capture land N edges after accept.
                        cnt        <= 4'(SETTLE_CYCLES - 1);
                    end
                end
                SETTLE: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_p <= mul_p;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Directed bench for wallace_mul_arbiter. The external Wallace tree is
// modelled as a plain unsigned product of the registered operands.
module tb_wallace_mul_arbiter;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_p;
    logic        rsp_valid, rsp_id, rsp_ready, busy;
    logic [63:0] rsp_p;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc     = 0;
    int          prev_acc = 0;
    logic [63:0] exp_q[$];

    logic [31:0] r0_a_tbl [3] = '{32'd100, 32'd101, 32'd102};
    logic [31:0] r1_b_tbl [3] = '{32'd2, 32'd3, 32'd4};
    logic [63:0] exp_tbl  [6] = '{64'd300, 64'h1_0000_0000, 64'd303,
                                  64'h1_8000_0000, 64'd306, 64'h2_0000_0000};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    assign mul_p = {32'd0, mul_a} * {32'd0, mul_b};

    wallace_mul_arbiter #(.WIDTH(32), .SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_p      (mul_p),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_p      (rsp_p),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    // Called right after the accept edge; waits (bounded) for rsp_valid and
    // checks latency, product and id against the scoreboard.
    task automatic wait_rsp(input string tag, input logic chk_ops,
                            input logic [31:0] ea, input logic [31:0] eb,
                            input logic exp_id);
        int n;
        logic [63:0] exp_p;
        n = 0;
        while (!rsp_valid && n < 40) begin
            if (chk_ops) begin
                check({tag, "_mul_a"}, 64'(mul_a), 64'(ea));
                check({tag, "_mul_b"}, 64'(mul_b), 64'(eb));
            end
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(cyc - acc), 64'(SETTLE));
        exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check({tag, "_rsp_p"}, rsp_p, exp_p);
        check1({tag, "_rsp_id"}, rsp_id, exp_id);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k0;
        int k1;
        logic gid;

        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0;
        tick();
        tick();

        // Reset state, with a request pending that must not be accepted.
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
        check("rst_rsp_p", rsp_p, 64'd0);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check1("rst_rsp_id", rsp_id, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_ready0", req0_ready, 1'b0);
        check1("rst_ready1", req1_ready, 1'b0);

        // Single request 3*5.
        rst = 1'b0;
        #1;
        check1("t1_ready0", req0_ready, 1'b1);
        check1("t1_ready1", req1_ready, 1'b0);
        exp_q.push_back(64'd15);
        tick();
        acc = cyc;
        req0_valid = 1'b0;
        check1("t1_busy", busy, 1'b1);
        check1("t1_ready0_settle", req0_ready, 1'b0);
        wait_rsp("t1", 1'b1, 32'd3, 32'd5, 1'b0);
        tick();
        check1("t1_done_valid", rsp_valid, 1'b0);
        check1("t1_done_busy", busy, 1'b0);

        // Tie right after reset: req0 first, then req1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd11;
        #1;
        check1("t2_tie_ready0", req0_ready, 1'b1);
        check1("t2_tie_ready1", req1_ready, 1'b0);
        exp_q.push_back(64'd63);
        tick();
        acc = cyc;
        req0_valid = 1'b0;
        wait_rsp("t2a", 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        check1("t2_ready1", req1_ready, 1'b1);
        exp_q.push_back(64'd22);
        tick();
        acc = cyc;
        req1_valid = 1'b0;
        wait_rsp("t2b", 1'b0, 32'd0, 32'd0, 1'b1);
        tick();

        // Max operands on req1, operands held through SETTLE, then backpressure.
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF;
        #1;
        check1("t3_ready1", req1_ready, 1'b1);
        exp_q.push_back(64'hFFFF_FFFE_0000_0001);
        rsp_ready = 1'b0;
        tick();
        acc = cyc;
        req1_valid = 1'b0;
        wait_rsp("t3", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        req0_valid = 1'b1; req0_a = 32'd6; req0_b = 32'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check1($sformatf("t4_hold_valid%0d", i), rsp_valid, 1'b1);
            check($sformatf("t4_hold_p%0d", i), rsp_p, 64'hFFFF_FFFE_0000_0001);
            check1($sformatf("t4_hold_id%0d", i), rsp_id, 1'b1);
            check1($sformatf("t4_hold_ready0_%0d", i), req0_ready, 1'b0);
            check1($sformatf("t4_hold_ready1_%0d", i), req1_ready, 1'b0);
            check1($sformatf("t4_hold_busy%0d", i), busy, 1'b1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check1("t4_hs_ready0", req0_ready, 1'b0);
        tick();
        check1("t4_idle_valid", rsp_valid, 1'b0);
        check1("t4_idle_busy", busy, 1'b0);
        check1("t4_idle_ready0", req0_ready, 1'b1);
        exp_q.push_back(64'd42);
        tick();
        acc = cyc;
        req0_valid = 1'b0;
        wait_rsp("t4b", 1'b0, 32'd0, 32'd0, 1'b0);
        tick();

        // Reset in SETTLE at cnt=2 discards the operation.
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd10;
        #1;
        check1("t5_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check1($sformatf("t5_no_rsp%0d", i), rsp_valid, 1'b0);
            tick();
        end
        check("t5_mul_a", 64'(mul_a), 64'd0);
        check("t5_mul_b", 64'(mul_b), 64'd0);
        check1("t5_busy", busy, 1'b0);
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1;
        #1;
        check1("t5_tie_ready0", req0_ready, 1'b1);
        check1("t5_tie_ready1", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;

        // Continuous contention: six transactions alternating 0,1,0,1,0,1.
        k0 = 0;
        k1 = 0;
        req0_valid = 1'b1; req0_a = r0_a_tbl[0]; req0_b = 32'd3;
        req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = r1_b_tbl[0];
        rsp_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            int n;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 40) begin
                tick();
                n++;
            end
            gid = req1_ready;
            check1($sformatf("t6_id%0d", i), gid, 1'(i % 2));
            exp_q.push_back(exp_tbl[i]);
            tick();
            acc = cyc;
            if (i > 0) begin
                check($sformatf("t6_spacing%0d", i), 64'(acc - prev_acc), 64'(SETTLE + 2));
            end
            prev_acc = acc;
            if (gid == 1'b0) begin
                k0++;
                if (k0 < 3) req0_a = r0_a_tbl[k0];
                else        req0_valid = 1'b0;
            end else begin
                k1++;
                if (k1 < 3) req1_b = r1_b_tbl[k1];
                else        req1_valid = 1'b0;
            end
            wait_rsp($sformatf("t6_%0d", i), 1'b0, 32'd0, 32'd0, 1'(i % 2));
            tick();
        end
        check1("t6_end_busy", busy, 1'b0);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
